// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Two-sensor coin validator. Synchronises the raw 5/- and 10/-
//               sensors, measures the high width of each coin pulse, emits a
//               one-cycle coin code for valid coins, rejects short, mixed or
//               lock-out coins, and flags a jammed sensor.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor #(
    parameter int MIN_PULSE   = 3,
    parameter int MAX_PULSE   = 20,
    parameter int LOCK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_sns5,
    input  logic       i_sns10,
    input  logic       i_vend_busy,
    output logic [1:0] o_coin_code,
    output logic       o_reject,
    output logic       o_jam,
    output logic [7:0] o_coin_cnt
);

    // Width counter must hold MAX_PULSE+1 (its saturation value)
    localparam int c_WID_W = $clog2(MAX_PULSE + 2);
    localparam int c_LCK_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);

    localparam logic [c_WID_W-1:0] c_MIN  = c_WID_W'(MIN_PULSE);
    localparam logic [c_WID_W-1:0] c_MAX  = c_WID_W'(MAX_PULSE);
    localparam logic [c_WID_W-1:0] c_SAT  = c_WID_W'(MAX_PULSE + 1);
    localparam logic [c_WID_W-1:0] c_ONE  = c_WID_W'(1);
    localparam logic [c_LCK_W-1:0] c_LOCK = c_LCK_W'(LOCK_CYCLES);
    localparam logic [c_LCK_W-1:0] c_LONE = c_LCK_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MEAS5  = 3'd1,
        S_MEAS10 = 3'd2,
        S_EMIT   = 3'd3,
        S_REFUSE = 3'd4,
        S_JAM    = 3'd5,
        S_LOCK   = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_s5_meta;
    logic               r_s5;
    logic               r_s10_meta;
    logic               r_s10;
    logic               r_busy_d;
    logic [c_WID_W-1:0] r_width;
    logic [c_WID_W-1:0] w_width_nxt;
    logic [c_LCK_W-1:0] r_lock_cnt;
    logic [c_LCK_W-1:0] w_lock_cnt_nxt;
    logic               r_lock_coin;
    logic               w_lock_coin_nxt;
    logic [1:0]         r_coin_code;
    logic [1:0]         w_code_nxt;
    logic               r_reject;
    logic               w_reject_nxt;
    logic               r_jam;
    logic               w_jam_nxt;
    logic [7:0]         r_coin_cnt;

    logic               w_any;
    logic               w_meas;
    logic               w_other;
    logic               w_busy_fall;

    assign w_any       = r_s5 | r_s10;
    // Sensor being measured and the opposite sensor for the current MEAS state
    assign w_meas      = (r_state == S_MEAS5) ? r_s5  : r_s10;
    assign w_other     = (r_state == S_MEAS5) ? r_s10 : r_s5;
    assign w_busy_fall = r_busy_d & ~i_vend_busy;

    // Two-flop synchronisers for the raw coin sensors, plus vend_busy history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s5_meta  <= 1'b0;
            r_s5       <= 1'b0;
            r_s10_meta <= 1'b0;
            r_s10      <= 1'b0;
            r_busy_d   <= 1'b0;
        end else begin
            r_s5_meta  <= i_sns5;
            r_s5       <= r_s5_meta;
            r_s10_meta <= i_sns10;
            r_s10      <= r_s10_meta;
            r_busy_d   <= i_vend_busy;
        end
    end

    // Lock-out counter: reloads on the vend_busy falling edge, then counts down
    always_comb begin
        w_lock_cnt_nxt = r_lock_cnt;
        if (w_busy_fall) begin
            w_lock_cnt_nxt = c_LOCK;
        end else if (r_lock_cnt != '0) begin
            w_lock_cnt_nxt = r_lock_cnt - c_LONE;
        end
    end

    // Next-state and next-output decode; outputs are registered from here
    always_comb begin
        w_state_nxt     = r_state;
        w_width_nxt     = r_width;
        w_lock_coin_nxt = r_lock_coin;
        w_code_nxt      = 2'b00;
        w_reject_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_vend_busy || w_busy_fall || (r_lock_cnt != '0)) begin
                    w_state_nxt     = S_LOCK;
                    w_lock_coin_nxt = w_any;
                end else if (r_s5 && r_s10) begin
                    w_state_nxt  = S_REFUSE;
                    w_reject_nxt = 1'b1;
                end else if (r_s5) begin
                    w_state_nxt = S_MEAS5;
                    w_width_nxt = c_ONE;
                end else if (r_s10) begin
                    w_state_nxt = S_MEAS10;
                    w_width_nxt = c_ONE;
                end
            end

            S_MEAS5, S_MEAS10: begin
                if (i_vend_busy) begin
                    // Coin in flight is refused once it has cleared the sensors
                    w_state_nxt     = S_LOCK;
                    w_lock_coin_nxt = 1'b1;
                end else if (w_other) begin
                    w_state_nxt  = S_REFUSE;
                    w_reject_nxt = 1'b1;
                end else if (w_meas) begin
                    if (r_width >= c_MAX) begin
                        w_state_nxt  = S_JAM;
                        w_width_nxt  = c_SAT;
                        w_reject_nxt = 1'b1;
                    end else begin
                        w_width_nxt = r_width + c_ONE;
                    end
                end else if (r_width >= c_MIN) begin
                    w_state_nxt = S_EMIT;
                    w_code_nxt  = (r_state == S_MEAS5) ? 2'b01 : 2'b10;
                end else begin
                    w_state_nxt  = S_REFUSE;
                    w_reject_nxt = 1'b1;
                end
            end

            S_EMIT: begin
                if (i_vend_busy) begin
                    w_state_nxt     = S_LOCK;
                    w_lock_coin_nxt = w_any;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_REFUSE: begin
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_JAM: begin
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_LOCK: begin
                if (w_any) begin
                    w_lock_coin_nxt = 1'b1;
                end else if (r_lock_coin) begin
                    w_reject_nxt    = 1'b1;
                    w_lock_coin_nxt = 1'b0;
                end
                if (!i_vend_busy && !w_busy_fall && (r_lock_cnt == '0) && !w_any) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_jam_nxt = (w_state_nxt == S_JAM);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_width     <= '0;
            r_lock_cnt  <= '0;
            r_lock_coin <= 1'b0;
            r_coin_code <= 2'b00;
            r_reject    <= 1'b0;
            r_jam       <= 1'b0;
            r_coin_cnt  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_width     <= w_width_nxt;
            r_lock_cnt  <= w_lock_cnt_nxt;
            r_lock_coin <= w_lock_coin_nxt;
            r_coin_code <= w_code_nxt;
            r_reject    <= w_reject_nxt;
            r_jam       <= w_jam_nxt;
            if ((w_code_nxt != 2'b00) && (r_coin_cnt != 8'hFF)) begin
                r_coin_cnt <= r_coin_cnt + 8'd1;
            end
        end
    end

    assign o_coin_code = r_coin_code;
    assign o_reject    = r_reject;
    assign o_jam       = r_jam;
    assign o_coin_cnt  = r_coin_cnt;

endmodule
`default_nettype wire

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter MIN_PULSE, default 3: minimum valid coin-sensor high width, in clk cycles after synchronization.
REQ-002 Parameter MAX_PULSE, default 20: maximum valid coin-sensor high width; a longer pulse is a jam.
REQ-003 Parameter LOCK_CYCLES, default 4: cycles coins stay refused after vend_busy falls.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 sns5  input  1  raw 5/- coin sensor, asynchronous to clk, high while a coin passes.
REQ-007 sns10  input  1  raw 10/- coin sensor, asynchronous to clk, high while a coin passes.
REQ-008 vend_busy  input  1  high while the vending machine is dispensing; coins arriving then are refused.
REQ-009 coin_code  output  2  coin code to the vending machine: 00 none, 01 = 5/-, 10 = 10/-; 11 never driven.
REQ-010 reject  output  1  one-cycle pulse per refused coin.
REQ-011 jam  output  1  level, high while a sensor is stuck high beyond MAX_PULSE.
REQ-012 coin_cnt  output  8  accepted-coin count, saturating at 255.

Function
REQ-013 sns5 and sns10 shall each pass through a 2-flop synchronizer; all logic below uses the synchronized signals s5/s10.
REQ-014 FSM states: IDLE, MEAS5, MEAS10, EMIT, REFUSE, JAM, LOCK.
REQ-015 IDLE: s5 alone high -> MEAS5; s10 alone high -> MEAS10; both high -> REFUSE; width counter loads 1 on entry to MEAS5/MEAS10.
REQ-016 MEAS5/MEAS10: width counter increments each cycle the measured sensor stays high; if the other sensor goes high -> REFUSE.
REQ-017 MEAS: measured sensor low with MIN_PULSE <= width <= MAX_PULSE -> EMIT; low with width < MIN_PULSE -> REFUSE.
REQ-018 MEAS: width reaching MAX_PULSE+1 -> JAM.
REQ-019 EMIT: coin_code = 01 (from MEAS5) or 10 (from MEAS10) for exactly one cycle; coin_cnt increments in the same cycle unless already 255; next state IDLE.
REQ-020 REFUSE: reject = 1 for exactly one cycle; next state waits in REFUSE (reject low) until s5 = s10 = 0, then IDLE.
REQ-021 JAM: jam = 1 and reject pulses once on entry; jam stays high until s5 = s10 = 0, then jam clears and next state IDLE; coin_code stays 00.
REQ-022 vend_busy high in IDLE, or at any point during MEAS -> LOCK; a coin in flight is refused with a reject pulse once both sensors are low.
REQ-023 LOCK: lock counter loads LOCK_CYCLES when vend_busy falls; state stays LOCK while vend_busy is high or the counter is nonzero; exit to IDLE only with the counter at 0 and both sensors low.
REQ-024 vend_busy rising while in EMIT: the EMIT pulse still completes and the next state is LOCK.
REQ-025 Latency: the raw sensor falling edge reaches coin_code = nonzero on the 3rd posedge after it (2 synchronizer + 1 decision), in a single cycle.
REQ-026 coin_code, reject, and jam are registered outputs; coin_code is never nonzero on two consecutive cycles.
REQ-027 Width counter saturates at MAX_PULSE+1; the counter is sized as ceil(log2(MAX_PULSE+2)) bits.

Reset
REQ-028 reset low, asynchronously: state = IDLE, coin_code = 00, reject = 0, jam = 0, coin_cnt = 0, synchronizers, width counter and lock counter = 0.
REQ-029 reset asserted during MEAS or EMIT aborts the coin with no code or reject output; after release a still-high sensor is treated as a new pulse.
REQ-030 No output shall toggle in the first 2 cycles after reset release, other than by the asynchronous clear itself.

Verification
REQ-031 sns5 high for 5 cycles, vend_busy = 0 -> coin_code = 01 for one cycle, 3 cycles after sns5 falls; coin_cnt 0 -> 1.
REQ-032 sns10 high for 2 cycles -> reject pulse once, coin_code stays 00, coin_cnt unchanged.
REQ-033 sns5 high for 30 cycles -> jam = 1 from the 21st synchronized high cycle with one reject pulse; jam clears after sns5 falls; no coin_code.
REQ-034 sns5 and sns10 high together for 6 cycles -> single reject pulse, coin_code 00.
REQ-035 vend_busy high for 10 cycles, sns10 pulsed 5 cycles within it -> reject; sns10 5-cycle pulse 2 cycles after vend_busy falls -> reject (LOCK); the same pulse 6 cycles after the fall -> coin_code = 10.
REQ-036 coin_cnt preloaded to 255 via 255 valid coins, one more valid coin -> coin_code pulses, coin_cnt stays 255; reset low mid-MEAS -> all outputs 0 immediately.
